seg7_scan_decoder: RTL

Monitors a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode enables) and reconstructs the 5-bit digit code shown on each digit position. It is the inverse of our 5-bit-code-to-segment LUT. It sits on the display-driver outputs for self-check and readback. Patterns must be stable for a programmable number of clocks before they are accepted, so anode-switching glitches are rejected.

---
 rtl/seg7_scan_decoder.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Readback monitor for a multiplexed, active-low 7-segment bus: recovers the
// 5-bit code shown on each digit once its segment/anode pattern is stable.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int IDX_W         = 2,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    iCLK,
  input  logic                    iRST_N,
  input  logic [6:0]              iSEG,
  input  logic [NUM_DIGITS-1:0]   iAN,
  input  logic                    iCLR,
  output logic [5*NUM_DIGITS-1:0] oDIG,
  output logic [NUM_DIGITS-1:0]   oVALID,
  output logic                    oUPD,
  output logic [IDX_W-1:0]        oUPD_IDX,
  output logic                    oERR
);

  localparam int         SW       = 7 + NUM_DIGITS;
  localparam logic [7:0] CNT_MAX  = 8'(STABLE_CYCLES);
  localparam bit         ONE_SHOT = (STABLE_CYCLES == 1);

  typedef enum logic [1:0] {IDLE = 2'd0, QUAL = 2'd1, HELD = 2'd2} state_e;

  logic [6:0]              seg_m_q, seg_s_q;
  logic [NUM_DIGITS-1:0]   an_m_q, an_s_q;
  state_e                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [SW-1:0]           held_q, held_d;
  logic [5*NUM_DIGITS-1:0] dig_q, dig_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic                    upd_q, upd_d;
  logic [IDX_W-1:0]        upd_idx_q, upd_idx_d;
  logic                    err_q, err_d;
  logic [SW-1:0]           sample_s;
  logic                    sel_s;
  logic [IDX_W-1:0]        idx_s;
  logic [5:0]              dec_s;
  logic                    commit_s;

  function automatic logic one_hot_low(input logic [NUM_DIGITS-1:0] an);
    int zeros;
    zeros = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) zeros++;
    end
    return (zeros == 1);
  endfunction

  function automatic logic [IDX_W-1:0] low_index(input logic [NUM_DIGITS-1:0] an);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // Returns {recognised, code}; inverse of the code-to-segment table.
  function automatic logic [5:0] decode7(input logic [6:0] seg);
    case (seg)
      7'b1000000: return {1'b1, 5'h00};
      7'b1111001: return {1'b1, 5'h01};
      7'b0100100: return {1'b1, 5'h02};
      7'b0110000: return {1'b1, 5'h03};
      7'b0011001: return {1'b1, 5'h04};
      7'b0010010: return {1'b1, 5'h05};
      7'b0000010: return {1'b1, 5'h06};
      7'b1111000: return {1'b1, 5'h07};
      7'b0000000: return {1'b1, 5'h08};
      7'b0011000: return {1'b1, 5'h09};
      7'b0001000: return {1'b1, 5'h0A};
      7'b0000011: return {1'b1, 5'h0B};
      7'b1000110: return {1'b1, 5'h0C};
      7'b0100001: return {1'b1, 5'h0D};
      7'b0000110: return {1'b1, 5'h0E};
      7'b0001110: return {1'b1, 5'h0F};
      7'b0001001: return {1'b1, 5'h10};
      7'b1111111: return {1'b1, 5'h11};
      default:    return {1'b0, 5'h00};
    endcase
  endfunction

  assign sample_s = {seg_s_q, an_s_q};
  assign sel_s    = one_hot_low(an_s_q);
  assign idx_s    = low_index(an_s_q);
  assign dec_s    = decode7(seg_s_q);

  // Two-flop synchronisers; idle bus (all ones) out of reset, untouched by iCLR.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      seg_m_q <= 7'h7F;
      seg_s_q <= 7'h7F;
      an_m_q  <= '1;
      an_s_q  <= '1;
    end else begin
      seg_m_q <= iSEG;
      seg_s_q <= seg_m_q;
      an_m_q  <= iAN;
      an_s_q  <= an_m_q;
    end
  end

  // Qualification state register.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      held_q  <= '1;
    end else if (iCLR) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      held_q  <= '1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      held_q  <= held_d;
    end
  end

  // Next-state: any change of the sample restarts the stability window.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    held_d   = held_q;
    commit_s = 1'b0;
    case (state_q)
      QUAL, HELD: begin
        if (sample_s == held_q) begin
          if (state_q == QUAL) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q + 8'd1 == CNT_MAX) begin
              state_d  = HELD;
              commit_s = 1'b1;
            end else begin
              state_d = QUAL;
            end
          end else begin
            cnt_d = CNT_MAX;
          end
        end else if (sel_s) begin
          held_d   = sample_s;
          cnt_d    = 8'd1;
          state_d  = ONE_SHOT ? HELD : QUAL;
          commit_s = ONE_SHOT;
        end else begin
          state_d = IDLE;
          cnt_d   = 8'd0;
        end
      end
      default: begin
        cnt_d = 8'd0;
        if (sel_s) begin
          held_d   = sample_s;
          cnt_d    = 8'd1;
          state_d  = ONE_SHOT ? HELD : QUAL;
          commit_s = ONE_SHOT;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  // Commit effects: recognised codes update the digit, unknown ones raise oERR.
  always_comb begin
    dig_d     = dig_q;
    valid_d   = valid_q;
    upd_d     = 1'b0;
    upd_idx_d = upd_idx_q;
    err_d     = err_q;
    if (commit_s && dec_s[5]) begin
      upd_d     = 1'b1;
      upd_idx_d = idx_s;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        if (idx_s == IDX_W'(k)) begin
          dig_d[5*k +: 5] = dec_s[4:0];
          valid_d[k]      = 1'b1;
        end
      end
    end else if (commit_s) begin
      err_d = 1'b1;
    end else begin
      upd_d = 1'b0;
    end
  end

  // Output registers; iCLR wins over a commit due on the same edge.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      dig_q     <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      err_q     <= 1'b0;
    end else if (iCLR) begin
      dig_q     <= '0;
      valid_q   <= '0;
      upd_q     <= 1'b0;
      upd_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      dig_q     <= dig_d;
      valid_q   <= valid_d;
      upd_q     <= upd_d;
      upd_idx_q <= upd_idx_d;
      err_q     <= err_d;
    end
  end

  assign oDIG     = dig_q;
  assign oVALID   = valid_q;
  assign oUPD     = upd_q;
  assign oUPD_IDX = upd_idx_q;
  assign oERR     = err_q;

endmodule
